uart_rx_fifo: RTL

- Receive-side buffer between the Duplex UART receiver and the UART APB register bridge.
- Captures each received byte, with its 3-bit error flags, on the rising edge of the receiver's done flag, and queues it.
- The APB bridge pops entries on RX-data register reads.
- Provides occupancy, threshold interrupt and sticky overrun/underflow/line-error status so bytes are not lost between APB polls.

---
 rtl/uart_rx_fifo_if.sv | 36 +++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/APB bridge side (master) and the receive FIFO (slave).
// Carries the capture inputs, the pop/control requests and all FIFO status outputs.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3,
  parameter int AW     = 4
);
  logic              rx_enable;
  logic              rx_done_flag;
  logic [DATA_W-1:0] rx_data;
  logic [ERR_W-1:0]  rx_error;
  logic              rd_en;
  logic              flush;
  logic              clr_flags;
  logic [AW:0]       threshold;
  logic [DATA_W-1:0] rd_data;
  logic [ERR_W-1:0]  rd_err;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              empty;
  logic              full;
  logic              level_irq;
  logic              overrun;
  logic              underflow;
  logic              err_sticky;

  modport slave (
    input  rx_enable, rx_done_flag, rx_data, rx_error, rd_en, flush, clr_flags, threshold,
    output rd_data, rd_err, rd_valid, count, empty, full, level_irq, overrun, underflow, err_sticky
  );

  modport master (
    output rx_enable, rx_done_flag, rx_data, rx_error, rd_en, flush, clr_flags, threshold,
    input  rd_data, rd_err, rd_valid, count, empty, full, level_irq, overrun, underflow, err_sticky
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the APB bridge: captures one byte plus error
// flags per rising edge of the done flag, pops with a registered read, keeps sticky status.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int DATA_W = 8,
  parameter int ERR_W  = 3
) (
  input  logic          aclk,
  input  logic          areset,
  uart_rx_fifo_if.slave bus
);
  localparam int          EW      = DATA_W + ERR_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ERR_W-1:0]  rd_err_q, rd_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              level_irq_q, level_irq_d;
  logic              overrun_q, overrun_d;
  logic              underflow_q, underflow_d;
  logic              err_sticky_q, err_sticky_d;
  logic              done_q, done_d;
  logic              push_evt, do_push, do_pop;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_err_d    = rd_err_q;
    rd_valid_d  = 1'b0;
    done_d      = bus.rx_done_flag;
    // Clear first so that a set event in the same cycle wins.
    overrun_d    = overrun_q    && !bus.clr_flags;
    underflow_d  = underflow_q  && !bus.clr_flags;
    err_sticky_d = err_sticky_q && !bus.clr_flags;

    push_evt = bus.rx_enable && bus.rx_done_flag && !done_q;
    do_pop   = bus.rd_en && !empty_q && !bus.flush;
    do_push  = push_evt && (!full_q || do_pop) && !bus.flush;

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (bus.rd_en && empty_q) begin
        underflow_d = 1'b1;
      end
      if (push_evt && full_q && !do_pop) begin
        overrun_d = 1'b1;
      end
      if (do_push && (|bus.rx_error)) begin
        err_sticky_d = 1'b1;
      end
      if (do_pop) begin
        {rd_err_d, rd_data_d} = mem[rptr_q];
        rd_valid_d            = 1'b1;
        rptr_d                = rptr_q + AW'(1);
      end
      if (do_push) begin
        wptr_d = wptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    empty_d     = (count_d == '0);
    full_d      = (count_d == DEPTH_C);
    level_irq_d = (bus.threshold != '0) && (count_d >= bus.threshold);
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wptr_q] <= {bus.rx_error, bus.rx_data};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_err_q     <= '0;
      rd_valid_q   <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      level_irq_q  <= 1'b0;
      overrun_q    <= 1'b0;
      underflow_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      done_q       <= 1'b1; // a done level held across reset release is not a new byte
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_err_q     <= rd_err_d;
      rd_valid_q   <= rd_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      level_irq_q  <= level_irq_d;
      overrun_q    <= overrun_d;
      underflow_q  <= underflow_d;
      err_sticky_q <= err_sticky_d;
      done_q       <= done_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.level_irq  = level_irq_q;
  assign bus.overrun    = overrun_q;
  assign bus.underflow  = underflow_q;
  assign bus.err_sticky = err_sticky_q;
endmodule
